// File: rtl/dcp_frame_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : dcp_frame_sequencer_if
// Purpose  : Groups the frame-sequencer control and status signals.
//            The slave modport is the sequencer's view; the master modport
//            is the view of the surrounding AXI4-Stream top level.
// Signals  : start, in_beat, out_beat, ale_done      (master -> slave)
//            ale_clear, ale_enable, te_enable, m_tlast, o_intr,
//            frame_done, busy, phase[1:0], overrun, timeout,
//            in_count[CNT_W-1:0]                     (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface dcp_frame_sequencer_if #(
   parameter int CNT_W = 20
);
   logic             start;
   logic             in_beat;
   logic             out_beat;
   logic             ale_done;
   logic             ale_clear;
   logic             ale_enable;
   logic             te_enable;
   logic             m_tlast;
   logic             o_intr;
   logic             frame_done;
   logic             busy;
   logic [1:0]       phase;
   logic             overrun;
   logic             timeout;
   logic [CNT_W-1:0] in_count;

   modport master (
      output start, in_beat, out_beat, ale_done,
      input  ale_clear, ale_enable, te_enable, m_tlast, o_intr,
             frame_done, busy, phase, overrun, timeout, in_count
   );

   modport slave (
      input  start, in_beat, out_beat, ale_done,
      output ale_clear, ale_enable, te_enable, m_tlast, o_intr,
             frame_done, busy, phase, overrun, timeout, in_count
   );
endinterface
`default_nettype wire

// File: rtl/dcp_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : dcp_frame_sequencer
// Purpose  : Two-pass frame controller for the DCP haze-removal datapath.
//            Pass 1 streams a frame through atmospheric light estimation,
//            waits for its result, then interrupts so the DMA replays the
//            frame. Pass 2 streams the replay through transmission
//            estimation / scene recovery, counts output beats, drives TLAST
//            and flags frame completion.
// Ports    : clk      - system clock
//            rst      - asynchronous active-high reset
//            bus      - dcp_frame_sequencer_if.slave (control in, status out)
// Revision : 1.0 - initial release
// ============================================================================
module dcp_frame_sequencer #(
   parameter int IMG_WIDTH   = 512,
   parameter int IMG_HEIGHT  = 512,
   parameter int CNT_W       = 20,
   parameter int ALE_TIMEOUT = 4096
) (
   input  wire                    clk,
   input  wire                    rst,
   dcp_frame_sequencer_if.slave   bus
);

   localparam int               c_wd_w        = (ALE_TIMEOUT > 2) ? $clog2(ALE_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] c_frame_beats = CNT_W'(IMG_WIDTH * IMG_HEIGHT);
   localparam logic [CNT_W-1:0] c_last_beat   = CNT_W'(IMG_WIDTH * IMG_HEIGHT - 1);
   localparam logic [c_wd_w-1:0] c_wdog_last  = c_wd_w'(ALE_TIMEOUT - 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_ALE      = 3'd1;
   localparam logic [2:0] S_ALE_WAIT = 3'd2;
   localparam logic [2:0] S_TE       = 3'd3;
   localparam logic [2:0] S_ERR      = 3'd4;

   // state and registered outputs
   logic [2:0]        r_state;
   logic [CNT_W-1:0]  r_in_count;
   logic [CNT_W-1:0]  r_out_count;
   logic [c_wd_w-1:0] r_wdog;
   logic              r_ale_clear;
   logic              r_ale_enable;
   logic              r_te_enable;
   logic              r_o_intr;
   logic              r_frame_done;
   logic              r_busy;
   logic [1:0]        r_phase;
   logic              r_overrun;
   logic              r_timeout;

   // next-state values
   logic [2:0]        w_state_next;
   logic [CNT_W-1:0]  w_in_count_next;
   logic [CNT_W-1:0]  w_out_count_next;
   logic [c_wd_w-1:0] w_wdog_next;
   logic              w_ale_clear_next;
   logic              w_ale_enable_next;
   logic              w_te_enable_next;
   logic              w_o_intr_next;
   logic              w_frame_done_next;
   logic              w_busy_next;
   logic [1:0]        w_phase_next;
   logic              w_overrun_next;
   logic              w_timeout_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_in_count   <= '0;
         r_out_count  <= '0;
         r_wdog       <= '0;
         r_ale_clear  <= 1'b0;
         r_ale_enable <= 1'b0;
         r_te_enable  <= 1'b0;
         r_o_intr     <= 1'b0;
         r_frame_done <= 1'b0;
         r_busy       <= 1'b0;
         r_phase      <= 2'd0;
         r_overrun    <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_state      <= w_state_next;
         r_in_count   <= w_in_count_next;
         r_out_count  <= w_out_count_next;
         r_wdog       <= w_wdog_next;
         r_ale_clear  <= w_ale_clear_next;
         r_ale_enable <= w_ale_enable_next;
         r_te_enable  <= w_te_enable_next;
         r_o_intr     <= w_o_intr_next;
         r_frame_done <= w_frame_done_next;
         r_busy       <= w_busy_next;
         r_phase      <= w_phase_next;
         r_overrun    <= w_overrun_next;
         r_timeout    <= w_timeout_next;
      end
   end

   always_comb begin
      w_state_next      = r_state;
      w_in_count_next   = r_in_count;
      w_out_count_next  = r_out_count;
      w_wdog_next       = r_wdog;
      w_overrun_next    = r_overrun;
      w_timeout_next    = r_timeout;
      w_ale_clear_next  = 1'b0;
      w_o_intr_next     = 1'b0;
      w_frame_done_next = 1'b0;

      case (r_state)
         S_IDLE, S_ERR: begin
            if (bus.start) begin
               w_state_next     = S_ALE;
               w_in_count_next  = '0;
               w_out_count_next = '0;
               w_overrun_next   = 1'b0;
               w_timeout_next   = 1'b0;
               w_ale_clear_next = 1'b1;
            end
         end

         S_ALE: begin
            if (bus.in_beat) begin
               if (r_in_count < c_frame_beats) begin
                  w_in_count_next = r_in_count + CNT_W'(1);
               end
               if (r_in_count == c_last_beat) begin
                  w_state_next = S_ALE_WAIT;
                  w_wdog_next  = '0;
               end
            end
         end

         S_ALE_WAIT: begin
            // The whole frame has already been consumed; extra beats are
            // flagged but never counted.
            if (bus.in_beat) begin
               w_overrun_next = 1'b1;
            end
            if (bus.ale_done) begin
               w_state_next    = S_TE;
               w_in_count_next = '0;
               w_o_intr_next   = 1'b1;
            end else if (r_wdog == c_wdog_last) begin
               w_state_next   = S_ERR;
               w_timeout_next = 1'b1;
            end else begin
               w_wdog_next = r_wdog + c_wd_w'(1);
            end
         end

         S_TE: begin
            if (bus.in_beat) begin
               if (r_in_count < c_frame_beats) begin
                  w_in_count_next = r_in_count + CNT_W'(1);
               end else begin
                  w_overrun_next = 1'b1;
               end
            end
            if (bus.out_beat) begin
               if (r_out_count < c_frame_beats) begin
                  w_out_count_next = r_out_count + CNT_W'(1);
               end
               if (r_out_count == c_last_beat) begin
                  w_state_next      = S_IDLE;
                  w_frame_done_next = 1'b1;
                  // Keeps the interrupt a single-cycle pulse even for a
                  // one-beat frame, where the pass-2 entry pulse is still high.
                  w_o_intr_next     = ~r_o_intr;
               end
            end
         end

         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      w_ale_enable_next = (w_state_next == S_ALE);
      w_te_enable_next  = (w_state_next == S_TE);
      w_busy_next       = (w_state_next != S_IDLE);
      case (w_state_next)
         S_ALE, S_ALE_WAIT: w_phase_next = 2'd1;
         S_TE:              w_phase_next = 2'd2;
         S_ERR:             w_phase_next = 2'd3;
         default:           w_phase_next = 2'd0;
      endcase
   end

   assign bus.ale_clear  = r_ale_clear;
   assign bus.ale_enable = r_ale_enable;
   assign bus.te_enable  = r_te_enable;
   assign bus.o_intr     = r_o_intr;
   assign bus.frame_done = r_frame_done;
   assign bus.busy       = r_busy;
   assign bus.phase      = r_phase;
   assign bus.overrun    = r_overrun;
   assign bus.timeout    = r_timeout;
   assign bus.in_count   = r_in_count;

   // TLAST follows the current output beat so it lines up with that beat.
   assign bus.m_tlast = bus.out_beat & (r_state == S_TE) & (r_out_count == c_last_beat);

endmodule
`default_nettype wire

// File: tb/tb_dcp_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcp_frame_sequencer
// Purpose  : Directed self-checking bench for dcp_frame_sequencer with a
//            4x3 frame (12 beats) and an 8-cycle ALE watchdog.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcp_frame_sequencer;

   localparam int c_cnt_w = 8;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   dcp_frame_sequencer_if #(.CNT_W(c_cnt_w)) sif ();

   dcp_frame_sequencer #(
      .IMG_WIDTH   (4),
      .IMG_HEIGHT  (3),
      .CNT_W       (c_cnt_w),
      .ALE_TIMEOUT (8)
   ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (sif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed_in(input int n);
      for (int i = 0; i < n; i++) begin
         sif.in_beat = 1'b1;
         tick();
      end
      sif.in_beat = 1'b0;
   endtask

   // Output beats numbered from 'first'; TLAST is required on beat index 11.
   task automatic feed_out(input int first, input int n);
      for (int i = 0; i < n; i++) begin
         sif.out_beat = 1'b1;
         #1;
         chk("m_tlast", {31'd0, sif.m_tlast}, {31'd0, (first + i) == 11});
         tick();
      end
      sif.out_beat = 1'b0;
   endtask

   initial begin
      n_cmp        = 0;
      n_fail       = 0;
      rst          = 1'b1;
      sif.start    = 1'b0;
      sif.in_beat  = 1'b0;
      sif.out_beat = 1'b0;
      sif.ale_done = 1'b0;
      tick();
      tick();
      // ---------------- reset state
      chk("rst_busy",  {31'd0, sif.busy}, 32'd0);
      chk("rst_phase", {30'd0, sif.phase}, 32'd0);
      chk("rst_misc",  {26'd0, sif.ale_clear, sif.ale_enable, sif.te_enable,
                        sif.o_intr, sif.frame_done, sif.overrun}, 32'd0);
      chk("rst_cnt",   {24'd0, sif.in_count}, 32'd0);
      rst = 1'b0;
      tick();

      // ---------------- idle: in_beat ignored, out_beat gives no TLAST
      sif.in_beat  = 1'b1;
      sif.out_beat = 1'b1;
      #1;
      chk("idle_tlast", {31'd0, sif.m_tlast}, 32'd0);
      tick();
      sif.in_beat  = 1'b0;
      sif.out_beat = 1'b0;
      chk("idle_overrun", {31'd0, sif.overrun}, 32'd0);
      chk("idle_cnt", {24'd0, sif.in_count}, 32'd0);

      // ---------------- normal frame
      sif.start = 1'b1;
      tick();
      sif.start = 1'b0;
      chk("n_ale_clear", {31'd0, sif.ale_clear}, 32'd1);
      chk("n_ale_en",    {31'd0, sif.ale_enable}, 32'd1);
      chk("n_phase1",    {30'd0, sif.phase}, 32'd1);
      tick();
      chk("n_ale_clear_drop", {31'd0, sif.ale_clear}, 32'd0);
      feed_in(11);
      chk("n_cnt11", {24'd0, sif.in_count}, 32'd11);
      chk("n_ale_en11", {31'd0, sif.ale_enable}, 32'd1);
      feed_in(1);
      chk("n_cnt12", {24'd0, sif.in_count}, 32'd12);
      chk("n_wait_ale_en", {31'd0, sif.ale_enable}, 32'd0);
      chk("n_wait_phase", {30'd0, sif.phase}, 32'd1);
      tick();
      tick();
      chk("n_wait_intr", {31'd0, sif.o_intr}, 32'd0);
      sif.ale_done = 1'b1;
      tick();
      sif.ale_done = 1'b0;
      chk("n_intr1", {31'd0, sif.o_intr}, 32'd1);
      chk("n_te_en", {31'd0, sif.te_enable}, 32'd1);
      chk("n_phase2", {30'd0, sif.phase}, 32'd2);
      chk("n_cnt_clr", {24'd0, sif.in_count}, 32'd0);
      tick();
      chk("n_intr1_drop", {31'd0, sif.o_intr}, 32'd0);
      feed_in(12);
      chk("n_te_cnt12", {24'd0, sif.in_count}, 32'd12);
      feed_out(0, 11);
      chk("n_te_en11", {31'd0, sif.te_enable}, 32'd1);
      chk("n_fd_early", {31'd0, sif.frame_done}, 32'd0);
      feed_out(11, 1);
      chk("n_frame_done", {31'd0, sif.frame_done}, 32'd1);
      chk("n_intr2", {31'd0, sif.o_intr}, 32'd1);
      chk("n_busy0", {31'd0, sif.busy}, 32'd0);
      chk("n_te_en0", {31'd0, sif.te_enable}, 32'd0);
      tick();
      chk("n_fd_drop", {31'd0, sif.frame_done}, 32'd0);
      chk("n_intr2_drop", {31'd0, sif.o_intr}, 32'd0);

      // ---------------- timeout
      sif.start = 1'b1;
      tick();
      sif.start = 1'b0;
      feed_in(12);
      for (int i = 0; i < 7; i++) tick();
      chk("to_early_phase", {30'd0, sif.phase}, 32'd1);
      chk("to_early_flag", {31'd0, sif.timeout}, 32'd0);
      tick();
      chk("to_flag", {31'd0, sif.timeout}, 32'd1);
      chk("to_phase3", {30'd0, sif.phase}, 32'd3);
      chk("to_enables", {30'd0, sif.ale_enable, sif.te_enable}, 32'd0);
      chk("to_busy", {31'd0, sif.busy}, 32'd1);
      sif.out_beat = 1'b1;
      #1;
      chk("err_tlast", {31'd0, sif.m_tlast}, 32'd0);
      sif.out_beat = 1'b0;
      tick();

      // ---------------- restart from error, overrun in ALE wait
      sif.start = 1'b1;
      tick();
      sif.start = 1'b0;
      chk("err_restart_to", {31'd0, sif.timeout}, 32'd0);
      chk("err_restart_phase", {30'd0, sif.phase}, 32'd1);
      chk("err_restart_clr", {31'd0, sif.ale_clear}, 32'd1);
      feed_in(12);
      chk("ov_w_pre", {31'd0, sif.overrun}, 32'd0);
      feed_in(1);
      chk("ov_wait_flag", {31'd0, sif.overrun}, 32'd1);
      chk("ov_wait_cnt", {24'd0, sif.in_count}, 32'd12);
      sif.ale_done = 1'b1;
      tick();
      sif.ale_done = 1'b0;
      chk("ov_intr", {31'd0, sif.o_intr}, 32'd1);
      chk("ov_sticky", {31'd0, sif.overrun}, 32'd1);
      feed_out(0, 12);
      chk("ov_frame_done", {31'd0, sif.frame_done}, 32'd1);
      tick();

      // ---------------- ale_done already high on entry, TE overrun, ignored start
      sif.start = 1'b1;
      tick();
      sif.start = 1'b0;
      chk("s_ov_cleared", {31'd0, sif.overrun}, 32'd0);
      feed_in(11);
      sif.ale_done = 1'b1;
      feed_in(1);
      chk("e_wait_phase", {30'd0, sif.phase}, 32'd1);
      chk("e_wait_intr", {31'd0, sif.o_intr}, 32'd0);
      tick();
      sif.ale_done = 1'b0;
      chk("e_intr", {31'd0, sif.o_intr}, 32'd1);
      chk("e_phase2", {30'd0, sif.phase}, 32'd2);
      feed_in(12);
      chk("t_ov_pre", {31'd0, sif.overrun}, 32'd0);
      feed_in(1);
      chk("t_ov_flag", {31'd0, sif.overrun}, 32'd1);
      chk("t_ov_cnt", {24'd0, sif.in_count}, 32'd12);
      feed_out(0, 5);
      sif.start = 1'b1;
      tick();
      sif.start = 1'b0;
      chk("ign_phase", {30'd0, sif.phase}, 32'd2);
      chk("ign_te_en", {31'd0, sif.te_enable}, 32'd1);
      chk("ign_clr", {31'd0, sif.ale_clear}, 32'd0);
      chk("ign_cnt", {24'd0, sif.in_count}, 32'd12);
      feed_out(5, 7);
      chk("ign_frame_done", {31'd0, sif.frame_done}, 32'd1);
      tick();

      // ---------------- asynchronous reset mid pass 2
      sif.start = 1'b1;
      tick();
      sif.start = 1'b0;
      feed_in(12);
      sif.ale_done = 1'b1;
      tick();
      sif.ale_done = 1'b0;
      feed_out(0, 5);
      #3;
      rst = 1'b1;
      #1;
      chk("ar_te_en", {31'd0, sif.te_enable}, 32'd0);
      chk("ar_busy", {31'd0, sif.busy}, 32'd0);
      chk("ar_phase", {30'd0, sif.phase}, 32'd0);
      chk("ar_done_intr", {30'd0, sif.frame_done, sif.o_intr}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("ar_post_done", {30'd0, sif.frame_done, sif.o_intr}, 32'd0);

      // ---------------- fresh frame, simultaneous beats in pass 2
      sif.start = 1'b1;
      tick();
      sif.start = 1'b0;
      feed_in(12);
      sif.ale_done = 1'b1;
      tick();
      sif.ale_done = 1'b0;
      tick();
      for (int i = 0; i < 12; i++) begin
         sif.in_beat  = 1'b1;
         sif.out_beat = 1'b1;
         #1;
         chk("sim_tlast", {31'd0, sif.m_tlast}, {31'd0, i == 11});
         tick();
      end
      sif.in_beat  = 1'b0;
      sif.out_beat = 1'b0;
      chk("sim_cnt", {24'd0, sif.in_count}, 32'd12);
      chk("sim_frame_done", {31'd0, sif.frame_done}, 32'd1);
      chk("sim_intr", {31'd0, sif.o_intr}, 32'd1);
      chk("sim_busy", {31'd0, sif.busy}, 32'd0);
      chk("sim_overrun", {31'd0, sif.overrun}, 32'd0);
      tick();
      chk("sim_fd_drop", {31'd0, sif.frame_done}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
